// File: rtl/cpu_pkg.sv
// Shared definitions for the core register bank.
//   DATA_W_DEF / NREGS_DEF : default datapath width and register count
//   cnt_w()                : width of a pending-write counter able to hold 0..max
//   issue_t                : decode-side issue bundle at the default geometry
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = $clog2(NREGS_DEF);

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  use_a;
    logic [ADDR_W_DEF-1:0] rs_a;
    logic                  use_b;
    logic [ADDR_W_DEF-1:0] rs_b;
    logic                  wr;
    logic [ADDR_W_DEF-1:0] rd;
  } issue_t;

endpackage

// File: rtl/regfile_scoreboard_sb_cell.sv
// Pending-write tracker for a single architectural register.
//   clk, rst : core clock, synchronous active-high reset
//   clr      : drop all outstanding writes (pipeline flush)
//   inc      : a writer to this register issued this cycle
//   dec      : a writeback to this register retired this cycle
//   cnt      : outstanding write count, saturating at MAX_INFLIGHT
//   pending  : cnt != 0
//   at_max   : cnt == MAX_INFLIGHT
module sb_cell
  import cpu_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CW           = cnt_w(MAX_INFLIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          pending,
  output logic          at_max
);

  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  // An issue and a retire in the same cycle cancel out; the guards keep the
  // counter inside 0..MAX_INFLIGHT even if the caller misbehaves.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CMAX) begin
      cnt <= cnt + CW'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign pending = (cnt != '0);
  assign at_max  = (cnt == CMAX);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register bank with per-register pending-write scoreboard for the pipelined
// core. Decode stalls on RAW/WAW hazards; a writeback in the issue cycle is
// bypassed into the registered read ports.
//   clk, rst                 : core clock, synchronous active-high reset
//   issue_*                  : decode-side instruction description
//   issue_ready / issue_fire : no hazard / instruction accepted this cycle
//   rd_data_a / rd_data_b    : source operands, valid one cycle after fire
//   wb_valid/wb_addr/wb_data : writeback from M/WB
//   flush                    : discard all outstanding writes
//   dbg_addr / dbg_data      : combinational peek at stored state (no bypass)
//   err_underflow            : sticky, writeback with nothing outstanding
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int NREGS        = NREGS_DEF,
  parameter int ADDR_W       = $clog2(NREGS),
  parameter int MAX_INFLIGHT = 3,
  parameter bit ZERO_REG     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_use_a,
  input  logic [ADDR_W-1:0] issue_rs_a,
  input  logic              issue_use_b,
  input  logic [ADDR_W-1:0] issue_rs_b,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  output logic              issue_fire,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              err_underflow
);

  localparam int CW = cnt_w(MAX_INFLIGHT);

  logic [DATA_W-1:0] regs [NREGS];
  logic [CW-1:0]     cnt  [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  atmax;

  logic              wb_eff;
  logic              blk_a, blk_b, blk_w;
  logic [DATA_W-1:0] rd_a_p1, rd_b_p1;

  // With a hardwired zero register, writebacks to r0 vanish entirely: no data
  // write, no count change, no underflow.
  assign wb_eff = wb_valid && !(ZERO_REG && wb_addr == '0);

  for (genvar r = 0; r < NREGS; r++) begin : g_cell
    logic inc_r, dec_r;
    assign inc_r = issue_fire && issue_wr && issue_rd == ADDR_W'(r) && !(ZERO_REG && r == 0);
    assign dec_r = wb_eff && wb_addr == ADDR_W'(r) && pend[r];
    sb_cell #(.MAX_INFLIGHT(MAX_INFLIGHT), .CW(CW)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .inc     (inc_r),
      .dec     (dec_r),
      .cnt     (cnt[r]),
      .pending (pend[r]),
      .at_max  (atmax[r])
    );
  end

  // A source with exactly one outstanding write is satisfied by a writeback
  // landing this cycle, since the read register captures wb_data directly.
  function automatic logic src_blocked(input logic use_src, input logic [ADDR_W-1:0] src);
    return use_src && cnt[src] != '0
           && !(cnt[src] == CW'(1) && wb_eff && wb_addr == src);
  endfunction

  function automatic logic [DATA_W-1:0] src_value(input logic [ADDR_W-1:0] src);
    if (wb_eff && wb_addr == src)   return wb_data;
    else if (ZERO_REG && src == '0) return '0;
    else                            return regs[src];
  endfunction

  assign blk_a = src_blocked(issue_use_a, issue_rs_a);
  assign blk_b = src_blocked(issue_use_b, issue_rs_b);
  // A same-cycle retire to rd frees a slot, so a full counter still accepts.
  assign blk_w = issue_wr && atmax[issue_rd] && !(wb_eff && wb_addr == issue_rd);

  assign issue_ready = !(blk_a || blk_b || blk_w) && !flush && !rst;
  assign issue_fire  = issue_valid && issue_ready;

  // ---- p0 -> p1: register file write, operand capture, error flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_eff) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a_p1 <= '0;
      rd_b_p1 <= '0;
    end else if (issue_fire) begin
      rd_a_p1 <= src_value(issue_rs_a);
      rd_b_p1 <= src_value(issue_rs_b);
    end
  end

  // A flush retires everything at once, so a writeback racing it is expected.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (wb_eff && !pend[wb_addr] && !flush) begin
      err_underflow <= 1'b1;
    end
  end

  assign rd_data_a = rd_a_p1;
  assign rd_data_b = rd_b_p1;
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_use_a, issue_use_b, issue_wr;
  logic [4:0]  issue_rs_a, issue_rs_b, issue_rd;
  logic        issue_ready, issue_fire;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        err_underflow;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(
    .DATA_W(32), .NREGS(32), .MAX_INFLIGHT(3), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_use_a(issue_use_a), .issue_rs_a(issue_rs_a),
    .issue_use_b(issue_use_b), .issue_rs_b(issue_rs_b),
    .issue_wr(issue_wr), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_fire(issue_fire),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_use_a = 0; issue_rs_a = 0; issue_use_b = 0; issue_rs_b = 0;
    issue_wr = 0; issue_rd = 0; wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ua, input logic [4:0] a, input logic ub, input logic [4:0] b,
                       input logic wr, input logic [4:0] rd);
    issue_valid = 1; issue_use_a = ua; issue_rs_a = a; issue_use_b = ub; issue_rs_b = b;
    issue_wr = wr; issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_valid = 1; wb_addr = addr; wb_data = data;
  endtask

  task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    idle();
    dbg_addr = 0;
    rst = 1;
    tick();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("ready_in_rst", {31'd0, issue_ready}, 32'd0);
    chk("fire_in_rst",  {31'd0, issue_fire},  32'd0);
    tick();
    rst = 0;
    idle();
    #1;
    // Reset state
    for (int i = 0; i < 32; i++) peek($sformatf("rst_reg%0d", i), 5'(i), 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_err",   {31'd0, err_underflow}, 32'd0);
    chk("rst_rda",   rd_data_a, 32'd0);
    chk("rst_rdb",   rd_data_b, 32'd0);

    // RAW stall and writeback bypass
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    #1;
    chk("raw_fire_rd5", {31'd0, issue_fire}, 32'd1);
    tick();
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("raw_stall1", {31'd0, issue_ready}, 32'd0);
    tick();
    chk("raw_stall2", {31'd0, issue_ready}, 32'd0);
    wb(5'd5, 32'hDEADBEEF);
    #1;
    chk("raw_bypass_ready", {31'd0, issue_ready}, 32'd1);
    chk("raw_bypass_fire",  {31'd0, issue_fire},  32'd1);
    tick();
    idle();
    #1;
    chk("raw_rda", rd_data_a, 32'hDEADBEEF);
    peek("raw_reg5", 5'd5, 32'hDEADBEEF);
    chk("raw_err", {31'd0, err_underflow}, 32'd0);

    // WAW saturation
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("waw_fire%0d", k), {31'd0, issue_fire}, 32'd1);
      tick();
    end
    chk("waw_full_stall", {31'd0, issue_ready}, 32'd0);
    wb(5'd7, 32'd1);
    #1;
    chk("waw_wb_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    wb_valid = 0;
    #1;
    chk("waw_still_full", {31'd0, issue_ready}, 32'd0);
    issue_valid = 0;
    for (int k = 0; k < 3; k++) begin
      wb(5'd7, 32'(k + 2));
      tick();
    end
    wb_valid = 0;
    #1;
    chk("waw_drain_err", {31'd0, err_underflow}, 32'd0);
    peek("waw_reg7", 5'd7, 32'd4);
    issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7);
    #1;
    chk("waw_drained_ready", {31'd0, issue_ready}, 32'd1);
    issue_valid = 0;

    // Flush
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    tick();
    tick();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    flush = 1;
    wb(5'd9, 32'h55);
    #1;
    chk("flush_ready", {31'd0, issue_ready}, 32'd0);
    chk("flush_fire",  {31'd0, issue_fire},  32'd0);
    tick();
    idle();
    #1;
    peek("flush_reg9", 5'd9, 32'h55);
    chk("flush_err", {31'd0, err_underflow}, 32'd0);
    issue(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("flush_cleared", {31'd0, issue_ready}, 32'd1);
    tick();
    idle();
    wb(5'd9, 32'h66);
    tick();
    idle();
    #1;
    chk("underflow_set", {31'd0, err_underflow}, 32'd1);
    peek("uflow_reg9", 5'd9, 32'h66);
    chk("pre_zero_rda", rd_data_a, 32'h55);

    // Hardwired zero register
    wb(5'd0, 32'h1234);
    tick();
    idle();
    peek("zero_reg0", 5'd0, 32'd0);
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
    tick();
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("zero_no_stall", {31'd0, issue_ready}, 32'd1);
    tick();
    idle();
    #1;
    chk("zero_rda", rd_data_a, 32'd0);

    // Dual port, hold, same-address, bypass at zero count
    wb(5'd3, 32'h10);
    tick();
    wb(5'd4, 32'h20);
    tick();
    idle();
    issue(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0);
    tick();
    idle();
    #1;
    chk("dual_rda", rd_data_a, 32'h10);
    chk("dual_rdb", rd_data_b, 32'h20);
    wb(5'd3, 32'h99);
    tick();
    idle();
    #1;
    chk("hold_rda", rd_data_a, 32'h10);
    chk("hold_rdb", rd_data_b, 32'h20);
    peek("hold_reg3", 5'd3, 32'h99);
    issue(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0);
    tick();
    idle();
    #1;
    chk("same_rda", rd_data_a, 32'h99);
    chk("same_rdb", rd_data_b, 32'h99);
    issue(1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 5'd0);
    wb(5'd4, 32'h77);
    peek("dbg_no_bypass", 5'd4, 32'h20);
    tick();
    idle();
    #1;
    chk("bypass_rda", rd_data_a, 32'h77);
    chk("bypass_rdb", rd_data_b, 32'h99);

    // Reset clears sticky error and registers
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst2_err", {31'd0, err_underflow}, 32'd0);
    chk("rst2_rda", rd_data_a, 32'd0);
    peek("rst2_reg3", 5'd3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
